apb_master: RTL and testbench

- Upstream APB requester for the APB_Slave RAM peripheral.
- Converts a simple valid/ready command interface (from CPU/bus bridge or test sequencer) into APB SETUP/ACCESS transfers on PADDR/PWRITE/PSEL/PENABLE/PWDATA.
- Waits for PREADY, captures PRDATA on reads and returns a one-entry response via valid/ready.
- One transfer outstanding at a time.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_timeout_counter.sv | 33 +++
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared defaults and state encoding for the APB requester.
package apb_pkg;

    localparam int DATAWIDTH_DEF      = 32;
    localparam int ADDRWIDTH_DEF      = 8;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; expired_o flags the cycle whose increment reaches the limit.
module apb_timeout_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_d == limit_i);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: cmd valid/ready in, SETUP/ACCESS on APB, one-entry response out.
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int DATAWIDTH      = DATAWIDTH_DEF,
    parameter int ADDRWIDTH      = ADDRWIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PWRITE,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic [DATAWIDTH-1:0] PWDATA,
    input  logic                 PREADY,
    input  logic [DATAWIDTH-1:0] PRDATA,
    output logic [1:0]           dbg_state_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
    end

    apb_state_e state_q, state_d;

    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    apb_timeout_counter u_timeout (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .clear_i   (state_q == ST_SETUP),
        .enable_i  ((state_q == ST_ACCESS) && !PREADY),
        .limit_i   (TIMEOUT_LIMIT),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PREADY is checked before the timeout so a completion on the limit edge is not an error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        PENABLE   = (state_q == ST_ACCESS);
        rsp_valid = (state_q == ST_RESP);
    end

    always_comb begin
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (state_q == ST_IDLE && cmd_valid) begin
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
        end
        if (state_q == ST_ACCESS) begin
            if (PREADY) begin
                rdata_d = pwrite_q ? '0 : PRDATA;
                err_d   = 1'b0;
            end else if (timeout_hit) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB slave with programmable wait states, response scoreboard.
// Timeout cases are exercised when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic [1:0]    dbg_state;

    logic [DW:0]   exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            slave_waits = 0;
    logic [DW-1:0] slave_rdata = '0;
    int            acc_cnt = 0;

    apb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Slave: asserts PREADY in the (slave_waits+1)-th ACCESS cycle; PRDATA is junk until then.
    initial begin
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                PREADY  = (acc_cnt == slave_waits);
                acc_cnt = acc_cnt + 1;
            end else begin
                PREADY  = 1'b0;
                acc_cnt = 0;
            end
            PRDATA = PREADY ? slave_rdata : (32'hBAD0_0000 | 32'(acc_cnt));
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Starts and ends at a falling edge with the DUT in IDLE.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input int rsp_delay,
                        input bit hold_valid);
        int          exp_acc;
        int          acc;
        bit          tmo;
        logic [DW:0] exp;
        tmo     = 1'b0;
        exp_acc = waits + 1;
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits >= TO) begin
            tmo     = 1'b1;
            exp_acc = TO;
        end
`endif
        exp_q.push_back(tmo ? {1'b1, {DW{1'b0}}} : {1'b0, (wr ? {DW{1'b0}} : rdata)});
        slave_waits = waits;
        slave_rdata = rdata;
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge PCLK);
        if (hold_valid) begin
            cmd_addr  = ~addr;
            cmd_wdata = ~wdata;
            cmd_write = ~wr;
        end else begin
            cmd_valid = 1'b0;
        end
        check("setup_sel_en", {PSEL, PENABLE}, 2'b10);
        check("setup_state", dbg_state, 2'b01);
        check("setup_cmd_ready", cmd_ready, 0);
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, wdata);
        acc = 0;
        @(negedge PCLK);
        while (PSEL && PENABLE && acc < 100) begin
            check("access_paddr", PADDR, addr);
            check("access_pwdata", PWDATA, wdata);
            acc = acc + 1;
            @(negedge PCLK);
        end
        check("access_cycles", acc, exp_acc);
        check("resp_sel_en", {PSEL, PENABLE}, 2'b00);
        for (int i = 0; i < rsp_delay; i++) begin
            check("resp_hold_valid", rsp_valid, 1);
            check("resp_cmd_ready", cmd_ready, 0);
            check("resp_paddr_held", PADDR, addr);
            @(negedge PCLK);
        end
        check("resp_valid", rsp_valid, 1);
        check("resp_state", dbg_state, 2'b11);
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check("rsp_err_rdata", {rsp_err, rsp_rdata}, exp);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check("post_hs_valid", rsp_valid, 0);
        check("post_hs_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge PCLK);

        check("rst_state", dbg_state, 2'b00);
        check("rst_sel_en", {PSEL, PENABLE}, 2'b00);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        PRESETn = 1'b1;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        check("idle_rsp_ready_noeffect", {rsp_valid, dbg_state}, 3'b000);
        rsp_ready = 1'b0;

        xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0000_0000, 0, 1'b0);
        xfer(1'b0, 8'h10, 32'h0000_0000, 3, 32'h12345678, 0, 1'b0);
        xfer(1'b1, 8'h20, 32'hA5A5A5A5, 1, 32'h0000_0000, 5, 1'b1);
        xfer(1'b0, 8'hFF, 32'h0000_0000, 0, 32'hCAFEF00D, 0, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, 8'h33, 32'h0000_0000, 1000, 32'h55AA55AA, 1, 1'b0);
        xfer(1'b0, 8'h44, 32'h0000_0000, TO - 1, 32'h87654321, 0, 1'b0);
`else
        xfer(1'b0, 8'h33, 32'h0000_0000, 20, 32'h55AA55AA, 1, 1'b0);
`endif

        // Reset in the middle of an ACCESS phase
        slave_waits = 1000;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h77;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("async_rst_sel_en", {PSEL, PENABLE}, 2'b00);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_paddr", PADDR, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("post_rst_idle", {cmd_ready, rsp_valid, PSEL, dbg_state}, 5'b10000);
        end

        for (int n = 0; n < 12; n++) begin
            xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom(),
                 $urandom_range(0, 5), $urandom(), $urandom_range(0, 3), 1'b0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors = errors + 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
